// File: rtl/hash_pkg.sv
// Shared types for the hash table probe: request opcodes, response status codes, FSM states
// and the saturating counter step used by the optional statistics.
package hash_pkg;

   typedef enum logic [1:0] {
      OpLookup   = 2'd0,
      OpInsert   = 2'd1,
      OpDelete   = 2'd2,
      OpReserved = 2'd3
   } hash_op_e;

   typedef enum logic [1:0] {
      StatusHit       = 2'd0,
      StatusMiss      = 2'd1,
      StatusCollision = 2'd2,
      StatusBadOp     = 2'd3
   } hash_status_e;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCmp,
      StWrite,
      StResp
   } probe_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] count);
      return (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
   endfunction

endpackage

// File: rtl/hash_bucket_ram.sv
// Direct-mapped bucket store, one read and one write port, registered read.
// Entry layout is {valid, key, value}; only the valid bits are reset.
module hash_bucket_ram #(
   parameter int unsigned NUM_ENTRIES = 256,
   parameter int unsigned KEY_WIDTH = 32,
   parameter int unsigned VALUE_WIDTH = 32,
   localparam int unsigned ADDR_WIDTH = $clog2(NUM_ENTRIES),
   localparam int unsigned DATA_WIDTH = KEY_WIDTH + VALUE_WIDTH,
   localparam int unsigned ENTRY_WIDTH = 1 + DATA_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic [ENTRY_WIDTH-1:0] rd_entry,
   input  logic                   wr_en,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [ENTRY_WIDTH-1:0] wr_entry
);

   logic [NUM_ENTRIES-1:0] valid_q;
   logic [DATA_WIDTH-1:0]  data_mem [NUM_ENTRIES];
   logic                   rd_valid_q;
   logic [DATA_WIDTH-1:0]  rd_data_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_addr] <= wr_entry[ENTRY_WIDTH-1];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= valid_q[rd_addr];
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         data_mem[wr_addr] <= wr_entry[DATA_WIDTH-1:0];
      end
      rd_data_q <= data_mem[rd_addr];
   end

   assign rd_entry = {rd_valid_q, rd_data_q};

endmodule

// File: rtl/hash_table_probe.sv
// Direct-mapped hash table probe: LOOKUP / INSERT / DELETE on the bucket chosen by hash_value.
// Define HASH_TABLE_STATS_EN to add saturating hit/miss/collision counters.
module hash_table_probe
   import hash_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES_PER_HASH_TABLE = 256,
   parameter int unsigned KEY_WIDTH = 32,
   parameter int unsigned VALUE_WIDTH = 32,
   localparam int unsigned HASH_WIDTH = $clog2(NUM_ENTRIES_PER_HASH_TABLE)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [KEY_WIDTH-1:0]   req_key,
   input  logic [HASH_WIDTH-1:0]  hash_value,
   input  logic [VALUE_WIDTH-1:0] req_value,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [1:0]             resp_status,
   output logic [VALUE_WIDTH-1:0] resp_value
`ifdef HASH_TABLE_STATS_EN
   ,
   output logic [31:0]            stat_hits,
   output logic [31:0]            stat_misses,
   output logic [31:0]            stat_collisions
`endif
);

   typedef struct packed {
      logic                   valid;
      logic [KEY_WIDTH-1:0]   key;
      logic [VALUE_WIDTH-1:0] value;
   } bucket_entry_t;

   probe_state_e           state_q, state_d;
   hash_op_e               op_q;
   logic [KEY_WIDTH-1:0]   key_q;
   logic [HASH_WIDTH-1:0]  idx_q;
   logic [VALUE_WIDTH-1:0] val_q;
   hash_status_e           status_q, status_d;
   logic [VALUE_WIDTH-1:0] value_q, value_d;
   logic                   do_write;
   logic                   key_hit;
   logic                   accept;
   logic                   wr_en;
   bucket_entry_t          rd_entry;
   bucket_entry_t          wr_entry;

   hash_bucket_ram #(
      .NUM_ENTRIES (NUM_ENTRIES_PER_HASH_TABLE),
      .KEY_WIDTH   (KEY_WIDTH),
      .VALUE_WIDTH (VALUE_WIDTH)
   ) u_bucket_ram (
      .clock    (clock),
      .reset    (reset),
      .rd_addr  (idx_q),
      .rd_entry (rd_entry),
      .wr_en    (wr_en),
      .wr_addr  (idx_q),
      .wr_entry (wr_entry)
   );

   assign accept = req_valid && req_ready;

   always_ff @(posedge clock) begin
      if (accept) begin
         op_q  <= hash_op_e'(req_op);
         key_q <= req_key;
         idx_q <= hash_value;
         val_q <= req_value;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Outcome is latched in CMP so status/value stay stable through WRITE and RESP.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         status_q <= StatusHit;
         value_q  <= '0;
      end else if (state_q == StCmp) begin
         status_q <= status_d;
         value_q  <= value_d;
      end
   end

   assign key_hit = rd_entry.valid && (rd_entry.key == key_q);

   always_comb begin
      status_d = StatusMiss;
      value_d  = '0;
      do_write = 1'b0;
      unique case (op_q)
         OpLookup: begin
            if (key_hit) begin
               status_d = StatusHit;
               value_d  = rd_entry.value;
            end
         end
         OpInsert: begin
            if (!rd_entry.valid || key_hit) begin
               status_d = StatusHit;
               do_write = 1'b1;
            end else begin
               status_d = StatusCollision;
            end
         end
         OpDelete: begin
            if (key_hit) begin
               status_d = StatusHit;
               do_write = 1'b1;
            end
         end
         default: status_d = StatusBadOp;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_valid) state_d = StRead;
         StRead:  state_d = StCmp;
         StCmp:   state_d = do_write ? StWrite : StResp;
         StWrite: state_d = StResp;
         StResp:  if (resp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready   = (state_q == StIdle);
      resp_valid  = (state_q == StResp);
      resp_status = status_q;
      resp_value  = value_q;
      wr_en       = (state_q == StWrite);
      // A DELETE rewrites the bucket with valid cleared; key/value contents become don't-care.
      wr_entry    = '{valid: (op_q == OpInsert), key: key_q, value: val_q};
   end

`ifdef HASH_TABLE_STATS_EN
   logic resp_fire;
   assign resp_fire = resp_valid && resp_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_hits       <= '0;
         stat_misses     <= '0;
         stat_collisions <= '0;
      end else if (resp_fire) begin
         unique case (status_q)
            StatusHit:       stat_hits       <= sat_inc(stat_hits);
            StatusMiss:      stat_misses     <= sat_inc(stat_misses);
            StatusCollision: stat_collisions <= sat_inc(stat_collisions);
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_hash_table_probe.sv
// Directed self-checking bench for hash_table_probe; checks stats when HASH_TABLE_STATS_EN is set.
module tb_hash_table_probe;

   localparam logic [1:0] OP_LOOKUP = 2'd0;
   localparam logic [1:0] OP_INSERT = 2'd1;
   localparam logic [1:0] OP_DELETE = 2'd2;
   localparam logic [1:0] OP_RSVD   = 2'd3;
   localparam logic [1:0] HIT       = 2'd0;
   localparam logic [1:0] MISS      = 2'd1;
   localparam logic [1:0] COLL      = 2'd2;
   localparam logic [1:0] BADOP     = 2'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [31:0] req_key = '0;
   logic [7:0]  hash_value = '0;
   logic [31:0] req_value = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [1:0]  resp_status;
   logic [31:0] resp_value;
`ifdef HASH_TABLE_STATS_EN
   logic [31:0] stat_hits, stat_misses, stat_collisions;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   hash_table_probe dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_key     (req_key),
      .hash_value  (hash_value),
      .req_value   (req_value),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_status (resp_status),
      .resp_value  (resp_value)
`ifdef HASH_TABLE_STATS_EN
      ,
      .stat_hits       (stat_hits),
      .stat_misses     (stat_misses),
      .stat_collisions (stat_collisions)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request, measures latency from the accept edge, optionally stalls the response.
   task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] key,
                         input logic [7:0] idx, input logic [31:0] val,
                         input logic [1:0] exp_st, input logic [31:0] exp_val,
                         input int exp_lat, input int hold);
      int n;
      int lat;
      resp_ready = (hold == 0);
      n = 0;
      @(negedge clock);
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "/ready"}, 64'(req_ready), 64'd1);
      req_valid  = 1'b1;
      req_op     = op;
      req_key    = key;
      hash_value = idx;
      req_value  = val;
      @(posedge clock);
      #1 req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "/status"}, 64'(resp_status), 64'(exp_st));
      chk({tag, "/value"}, 64'(resp_value), 64'(exp_val));
      for (int i = 0; i < hold; i++) begin
         @(posedge clock);
         #1;
         chk({tag, "/held"}, 64'({resp_valid, req_ready, resp_status, resp_value}),
             64'({1'b1, 1'b0, exp_st, exp_val}));
      end
      resp_ready = 1'b1;
      @(posedge clock);
      #1 chk({tag, "/done"}, 64'({resp_valid, req_ready}), 64'(2'b01));
   endtask

   initial begin
      #1 reset = 1'b1;
      #2;
      chk("reset/outputs", 64'({req_ready, resp_valid, resp_status, resp_value}),
          64'({1'b1, 1'b0, HIT, 32'd0}));
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b0;

      do_req("lookup_empty", OP_LOOKUP, 32'h11, 8'd5, 32'd0, MISS, 32'd0, 3, 0);
      do_req("insert_11", OP_INSERT, 32'h11, 8'd5, 32'hCAFE, HIT, 32'd0, 4, 0);
      do_req("lookup_11", OP_LOOKUP, 32'h11, 8'd5, 32'd0, HIT, 32'hCAFE, 3, 0);
      do_req("insert_coll", OP_INSERT, 32'h22, 8'd5, 32'd1, COLL, 32'd0, 3, 0);
      do_req("lookup_after_coll", OP_LOOKUP, 32'h11, 8'd5, 32'd0, HIT, 32'hCAFE, 3, 0);
      do_req("delete_11", OP_DELETE, 32'h11, 8'd5, 32'd0, HIT, 32'd0, 4, 0);
      do_req("delete_again", OP_DELETE, 32'h11, 8'd5, 32'd0, MISS, 32'd0, 3, 0);
      do_req("lookup_deleted", OP_LOOKUP, 32'h11, 8'd5, 32'd0, MISS, 32'd0, 3, 0);
      do_req("insert_255_bp", OP_INSERT, 32'hAB, 8'd255, 32'h1234, HIT, 32'd0, 4, 10);
      do_req("lookup_255", OP_LOOKUP, 32'hAB, 8'd255, 32'd0, HIT, 32'h1234, 3, 0);
      do_req("lookup_255_wrongkey", OP_LOOKUP, 32'hAC, 8'd255, 32'd0, MISS, 32'd0, 3, 0);
      do_req("bad_op", OP_RSVD, 32'hAB, 8'd255, 32'h5, BADOP, 32'd0, 3, 0);
      do_req("lookup_255_after_bad", OP_LOOKUP, 32'hAB, 8'd255, 32'd0, HIT, 32'h1234, 3, 0);

`ifdef HASH_TABLE_STATS_EN
      chk("stats/hits", 64'(stat_hits), 64'd7);
      chk("stats/misses", 64'(stat_misses), 64'd4);
      chk("stats/collisions", 64'(stat_collisions), 64'd1);
`endif

      // Reset while the INSERT sits in its WRITE cycle.
      @(negedge clock);
      req_valid  = 1'b1;
      req_op     = OP_INSERT;
      req_key    = 32'h33;
      hash_value = 8'd7;
      req_value  = 32'h9;
      @(posedge clock);
      #1 req_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      #1 chk("midwrite/in_reset", 64'({req_ready, resp_valid}), 64'(2'b10));
      @(posedge clock);
      @(negedge clock) reset = 1'b0;
      repeat (5) @(posedge clock);
      #1 chk("midwrite/no_resp", 64'(resp_valid), 64'd0);
`ifdef HASH_TABLE_STATS_EN
      chk("midwrite/stats", 64'({stat_hits, stat_misses} | 64'(stat_collisions)), 64'd0);
`endif
      do_req("lookup_33_after_rst", OP_LOOKUP, 32'h33, 8'd7, 32'd0, MISS, 32'd0, 3, 0);
      do_req("lookup_255_after_rst", OP_LOOKUP, 32'hAB, 8'd255, 32'd0, MISS, 32'd0, 3, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
